// File: rtl/execute_pkg.sv
// Shared types and constants for the multi-cycle EX stage.
package execute_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} ex_state_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  // A one-iteration multiplier still needs a one-bit counter.
  function automatic int cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/execute_mc_datapath.sv
// Single-cycle EX building blocks: ALU, operand muxes, shifter and adder.
module alu import execute_pkg::*; #(parameter int N = 64) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [N-1:0] y
);
  always_comb begin
    y = '0;
    case (ctrl)
      ALU_AND:   y = a & b;
      ALU_ORR:   y = a | b;
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end
endmodule

module mux2 #(parameter int W = 64) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module mux4 #(parameter int W = 64) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'b00: y = d0;
      2'b01: y = d1;
      2'b10: y = d2;
      2'b11: y = d3;
      default: y = d0;
    endcase
  end
endmodule

module sl2 #(parameter int W = 64) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = {a[W-3:0], 2'b00};
endmodule

module adder #(parameter int W = 64) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/execute_mc_mul_iter.sv
// Iterative unsigned multiplier retiring R multiplier bits per cycle into a 2N-bit accumulator.
module mul_iter import execute_pkg::*; #(
  parameter int N = 64,
  parameter int R = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  input  logic         high_sel,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int ITER = N / R;
  localparam int CW = cnt_width(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [N-1:0]   mcand;
  logic [N-1:0]   mplr;
  logic           high;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [N+R-1:0] partial;
  logic [N+R-1:0] sum;

  // The upper half plus one partial product fits in N+R bits, so no carry is lost.
  assign partial = {{R{1'b0}}, mcand} * {{N{1'b0}}, mplr[R-1:0]};
  assign sum     = {{R{1'b0}}, acc[2*N-1:N]} + partial;
  assign done    = busy && (cnt == LAST);
  assign result  = high ? acc[2*N-1:N] : acc[N-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      mplr  <= '0;
      high  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      mcand <= multiplicand;
      mplr  <= multiplier;
      high  <= high_sel;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc  <= {sum, acc[N-1:R]};
      mplr <= mplr >> R;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/execute_mc.sv
// LEGv8 EX stage: single-cycle ALU and branch target plus a stalling iterative multiplier.
module execute_mc import execute_pkg::*; #(
  parameter int N = 64,
  parameter int R = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         BranchReg,
  input  logic [1:0]   AluSrc,
  input  logic [3:0]   AluControl,
  input  logic         MulEn,
  input  logic         MulHigh,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic [N-1:0] readData3_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic         stall_E
);
  ex_state_t    state;
  logic [N-1:0] src_b;
  logic [N-1:0] alu_y;
  logic [N-1:0] branch_base;
  logic [N-1:0] imm_shifted;
  logic [N-1:0] mul_result;
  logic         mul_busy;
  logic         mul_done;
  logic         accept;

  mux4  #(.W(N)) u_src_b (.d0(readData2_E), .d1(signImm_E), .d2(readData3_E), .d3(readData3_E),
                          .sel(AluSrc), .y(src_b));
  alu   #(.N(N)) u_alu   (.a(readData1_E), .b(src_b), .ctrl(AluControl), .y(alu_y));
  mux2  #(.W(N)) u_base  (.d0(PC_E), .d1(readData1_E), .sel(BranchReg), .y(branch_base));
  sl2   #(.W(N)) u_sl2   (.a(signImm_E), .y(imm_shifted));
  adder #(.W(N)) u_add   (.a(branch_base), .b(imm_shifted), .y(PCBranch_E));

  mul_iter #(.N(N), .R(R)) u_mul (
    .clk(clk), .reset(reset), .start(accept), .abort(flush_E && (state != IDLE)),
    .multiplicand(readData1_E), .multiplier(src_b), .high_sel(MulHigh),
    .busy(mul_busy), .done(mul_done), .result(mul_result)
  );

  // Stall must rise in the accepting cycle itself so ID/EX holds the multiply.
  assign accept      = (state == IDLE) && valid_E && MulEn && !flush_E;
  assign stall_E     = accept || ((state == BUSY) && !flush_E);
  assign aluResult_E = (state == DONE) ? mul_result : alu_y;
  assign writeData_E = readData2_E;
  assign zero_E      = ~|aluResult_E;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state <= BUSY;
        BUSY: begin
          if (flush_E)        state <= IDLE;
          else if (mul_done)  state <= DONE;
          else if (!mul_busy) state <= IDLE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: branch/ALU paths, multiply latency, flush and reset, R = 1, 2, 4.
module tb_execute_mc;
  import execute_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_E, flush_E, BranchReg, MulEn, MulHigh;
  logic [1:0]  AluSrc;
  logic [3:0]  AluControl;
  logic [63:0] PC_E, signImm_E, readData1_E, readData2_E, readData3_E;

  logic [63:0] pcb2, res2, wd2, pcb1, res1, wd1, pcb4, res4, wd4;
  logic        z2, st2, z1, st1, z4, st4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  execute_mc #(.N(64), .R(2)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E), .BranchReg(BranchReg),
    .AluSrc(AluSrc), .AluControl(AluControl), .MulEn(MulEn), .MulHigh(MulHigh),
    .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
    .readData3_E(readData3_E), .PCBranch_E(pcb2), .aluResult_E(res2), .writeData_E(wd2),
    .zero_E(z2), .stall_E(st2));

  execute_mc #(.N(64), .R(1)) dut_r1 (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E), .BranchReg(BranchReg),
    .AluSrc(AluSrc), .AluControl(AluControl), .MulEn(MulEn), .MulHigh(MulHigh),
    .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
    .readData3_E(readData3_E), .PCBranch_E(pcb1), .aluResult_E(res1), .writeData_E(wd1),
    .zero_E(z1), .stall_E(st1));

  execute_mc #(.N(64), .R(4)) dut_r4 (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E), .BranchReg(BranchReg),
    .AluSrc(AluSrc), .AluControl(AluControl), .MulEn(MulEn), .MulHigh(MulHigh),
    .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
    .readData3_E(readData3_E), .PCBranch_E(pcb4), .aluResult_E(res4), .writeData_E(wd4),
    .zero_E(z4), .stall_E(st4));

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drives one instruction shortly after a rising edge so it is stable for the next cycle.
  task automatic applyStimulus(input logic v, input logic fl, input logic mul, input logic hi,
                               input logic br, input logic [1:0] src, input logic [3:0] ctrl,
                               input logic [63:0] pc, input logic [63:0] imm,
                               input logic [63:0] rd1, input logic [63:0] rd2);
    @(posedge clk);
    #1;
    valid_E = v; flush_E = fl; MulEn = mul; MulHigh = hi; BranchReg = br;
    AluSrc = src; AluControl = ctrl; PC_E = pc; signImm_E = imm;
    readData1_E = rd1; readData2_E = rd2; readData3_E = 64'hDEAD_BEEF;
  endtask

  // Holds a multiply until stall drops, then checks the DONE-cycle result and the stall length.
  task automatic runMul(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic hi, input logic [63:0] expected, input int exp_stalls);
    int stalls;
    stalls = 0;
    applyStimulus(1, 0, 1, hi, 0, 2'b00, ALU_ADD, 64'h0, 64'h0, a, b);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (st2) stalls++;
      else break;
    end
    checkOutput({tag, "_result"}, res2, expected);
    checkOutput({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    applyStimulus(0, 0, 0, 0, 0, 2'b00, ALU_ADD, 64'h0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    checkOutput({tag, "_no_reaccept"}, {63'h0, st2}, 64'h0);
  endtask

  initial begin
    int c1, c2, c4, high_seen;
    bit d1, d2, d4;
    logic [63:0] r1, r2, r4;

    reset = 1'b1;
    valid_E = 0; flush_E = 0; MulEn = 0; MulHigh = 0; BranchReg = 0;
    AluSrc = 2'b00; AluControl = ALU_AND;
    PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0; readData3_E = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_stall", {63'h0, st2}, 64'h0);
    checkOutput("reset_zero", {63'h0, z2}, 64'h1);

    applyStimulus(1, 0, 0, 0, 0, 2'b01, ALU_ADD, 64'h100, 64'h4, 64'h0, 64'h0);
    @(negedge clk);
    checkOutput("branch_pc", pcb2, 64'h110);

    applyStimulus(1, 0, 0, 0, 1, 2'b01, ALU_ADD, 64'h100, 64'h4, 64'h2000, 64'hABCD);
    @(negedge clk);
    checkOutput("branch_reg", pcb2, 64'h2010);
    checkOutput("write_data", wd2, 64'hABCD);

    applyStimulus(1, 0, 0, 0, 0, 2'b01, ALU_ADD, 64'h0, 64'h7, 64'h5, 64'h0);
    @(negedge clk);
    checkOutput("add_result", res2, 64'd12);
    checkOutput("add_zero", {63'h0, z2}, 64'h0);
    checkOutput("add_stall", {63'h0, st2}, 64'h0);

    applyStimulus(1, 0, 0, 0, 0, 2'b01, ALU_SUB, 64'h0, 64'h7, 64'h7, 64'h0);
    @(negedge clk);
    checkOutput("sub_result", res2, 64'h0);
    checkOutput("sub_zero", {63'h0, z2}, 64'h1);

    runMul("mul_low", 64'h1234, 64'h10, 0, 64'h12340, 33);
    runMul("umulh", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1, 64'h1, 33);
    runMul("mul_low_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // Squash the multiply in its tenth BUSY cycle.
    applyStimulus(1, 0, 1, 0, 0, 2'b00, ALU_ADD, 64'h0, 64'h0, 64'h55, 64'h3);
    repeat (10) @(posedge clk);
    #1 flush_E = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", {63'h0, st2}, 64'h0);
    applyStimulus(1, 0, 0, 0, 0, 2'b01, ALU_ADD, 64'h0, 64'h7, 64'h5, 64'h0);
    @(negedge clk);
    checkOutput("flush_next_add", res2, 64'd12);
    checkOutput("flush_next_stall", {63'h0, st2}, 64'h0);
    applyStimulus(0, 0, 0, 0, 0, 2'b01, ALU_ADD, 64'h0, 64'h7, 64'h5, 64'h0);
    high_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (st2 || res2 != 64'd12) high_seen++;
    end
    checkOutput("flush_no_done", 64'(high_seen), 64'h0);

    // Asynchronous reset in the fifth BUSY cycle.
    applyStimulus(1, 0, 1, 0, 0, 2'b00, ALU_ADD, 64'h0, 64'h0, 64'h77, 64'h3);
    repeat (5) @(posedge clk);
    #2;
    valid_E = 0; MulEn = 0; reset = 1'b1;
    #1;
    checkOutput("reset_busy_stall", {63'h0, st2}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_release_stall", {63'h0, st2}, 64'h0);

    // 3 x 3 on all three retire widths at once.
    applyStimulus(1, 0, 1, 0, 0, 2'b00, ALU_ADD, 64'h0, 64'h0, 64'h3, 64'h3);
    c1 = 0; c2 = 0; c4 = 0; d1 = 0; d2 = 0; d4 = 0;
    r1 = 'x; r2 = 'x; r4 = 'x;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!d1) begin if (st1) c1++; else begin d1 = 1; r1 = res1; end end
      if (!d2) begin if (st2) c2++; else begin d2 = 1; r2 = res2; end end
      if (!d4) begin if (st4) c4++; else begin d4 = 1; r4 = res4; end end
      if (k == 0) begin
        @(posedge clk);
        #1 valid_E = 0; MulEn = 0;
      end
    end
    checkOutput("r2_stalls", 64'(c2), 64'd33);
    checkOutput("r2_result", r2, 64'd9);
    checkOutput("r1_stalls", 64'(c1), 64'd65);
    checkOutput("r1_result", r1, 64'd9);
    checkOutput("r4_stalls", 64'(c4), 64'd17);
    checkOutput("r4_result", r4, 64'd9);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
